// File: rtl/mod_mul_vec.sv
// LANES-wide pipelined modular multiplier / fused multiply-add over Z_Q.
// Three register stages (product, Barrett quotient, reduction) with a global valid/ready stall.
module mod_mul_vec #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIDTH = 12,
  parameter int unsigned Q     = 3329,
  parameter int unsigned BK    = 2 * WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   mode_i,
  input  logic [LANES*WIDTH-1:0] a_i,
  input  logic [LANES*WIDTH-1:0] b_i,
  input  logic [LANES*WIDTH-1:0] c_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [LANES*WIDTH-1:0] result_o
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned MW = PW + BK + 1;
  localparam logic [BK:0]     BK_ONE    = {1'b1, {BK{1'b0}}};
  localparam logic [BK:0]     BARRETT_M = BK_ONE / (BK + 1)'(Q);
  localparam logic [PW-1:0]   Q_P       = PW'(Q);
  localparam logic [WIDTH:0]  Q_S       = (WIDTH + 1)'(Q);

  // Stage 1: product, addend and mode
  logic                        v1_q, v1_d;
  logic                        m1_q, m1_d;
  logic [LANES-1:0][PW-1:0]    p1_q, p1_d;
  logic [LANES-1:0][WIDTH-1:0] c1_q, c1_d;

  // Stage 2: product and quotient estimate
  logic                        v2_q, v2_d;
  logic                        m2_q, m2_d;
  logic [LANES-1:0][PW-1:0]    p2_q, p2_d;
  logic [LANES-1:0][PW-1:0]    q2_q, q2_d;
  logic [LANES-1:0][WIDTH-1:0] c2_q, c2_d;

  // Stage 3: reduced result
  logic                        v3_q, v3_d;
  logic [LANES*WIDTH-1:0]      res3_q, res3_d;

  logic            stall;
  logic            advance;
  logic [PW-1:0]   r;
  logic [WIDTH:0]  s;

  assign valid_o  = v3_q;
  assign result_o = res3_q;
  assign stall    = v3_q & ~ready_i;
  assign advance  = ~stall;
  assign ready_o  = rst & ~stall;

  always_comb begin
    v1_d   = v1_q;
    m1_d   = m1_q;
    p1_d   = p1_q;
    c1_d   = c1_q;
    v2_d   = v2_q;
    m2_d   = m2_q;
    p2_d   = p2_q;
    q2_d   = q2_q;
    c2_d   = c2_q;
    v3_d   = v3_q;
    res3_d = res3_q;
    r      = '0;
    s      = '0;

    if (advance) begin
      v1_d = valid_i;
      m1_d = mode_i;
      v2_d = v1_q;
      m2_d = m1_q;
      p2_d = p1_q;
      c2_d = c1_q;
      v3_d = v2_q;
      for (int unsigned n = 0; n < LANES; n++) begin
        p1_d[n] = PW'(a_i[n*WIDTH +: WIDTH]) * PW'(b_i[n*WIDTH +: WIDTH]);
        c1_d[n] = c_i[n*WIDTH +: WIDTH];

        q2_d[n] = PW'((MW'(p1_q[n]) * MW'(BARRETT_M)) >> BK);

        // Barrett leaves r in [0, 3Q); two trims bring it into [0, Q)
        r = p2_q[n] - q2_q[n] * Q_P;
        if (r >= Q_P) r = r - Q_P;
        if (r >= Q_P) r = r - Q_P;
        s = {1'b0, WIDTH'(r)};
        if (m2_q) begin
          s = s + {1'b0, c2_q[n]};
          if (s >= Q_S) s = s - Q_S;
        end
        res3_d[n*WIDTH +: WIDTH] = WIDTH'(s);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_q   <= 1'b0;
      m1_q   <= 1'b0;
      p1_q   <= '0;
      c1_q   <= '0;
      v2_q   <= 1'b0;
      m2_q   <= 1'b0;
      p2_q   <= '0;
      q2_q   <= '0;
      c2_q   <= '0;
      v3_q   <= 1'b0;
      res3_q <= '0;
    end else begin
      v1_q   <= v1_d;
      m1_q   <= m1_d;
      p1_q   <= p1_d;
      c1_q   <= c1_d;
      v2_q   <= v2_d;
      m2_q   <= m2_d;
      p2_q   <= p2_d;
      q2_q   <= q2_d;
      c2_q   <= c2_d;
      v3_q   <= v3_d;
      res3_q <= res3_d;
    end
  end

endmodule

// File: tb/tb_mod_mul_vec.sv
// Randomized bench for mod_mul_vec: per-beat (a*b + mode*c) mod Q reference with a FIFO scoreboard.
module tb_mod_mul_vec;

  localparam int unsigned LANES = 4;
  localparam int unsigned W     = 12;
  localparam int unsigned Q     = 3329;
  localparam int unsigned N     = LANES * W;

  logic         clk;
  logic         rst;
  logic         valid_i;
  logic         ready_o;
  logic         mode_i;
  logic [N-1:0] a_i, b_i, c_i;
  logic         valid_o;
  logic         ready_i;
  logic [N-1:0] result_o;

  mod_mul_vec #(.LANES(LANES), .WIDTH(W), .Q(Q), .BK(2 * W)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .mode_i   (mode_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .c_i      (c_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned n_del = 0;
  int unsigned n_stall = 0;
  int unsigned stall_left = 0;
  bit          rand_ready = 1'b0;
  logic [N-1:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] model(input logic m, input logic [N-1:0] a,
                                         input logic [N-1:0] b, input logic [N-1:0] c);
    logic [N-1:0] res;
    longint unsigned av, bv, cv;
    res = '0;
    for (int n = 0; n < LANES; n++) begin
      av = longint'(a[n*W +: W]);
      bv = longint'(b[n*W +: W]);
      cv = m ? longint'(c[n*W +: W]) : 64'd0;
      res[n*W +: W] = W'((av * bv + cv) % Q);
    end
    return res;
  endfunction

  function automatic logic [N-1:0] pack4(input int unsigned x0, input int unsigned x1,
                                         input int unsigned x2, input int unsigned x3);
    return {W'(x3), W'(x2), W'(x1), W'(x0)};
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] v;
    for (int n = 0; n < LANES; n++) v[n*W +: W] = W'($urandom_range(0, Q - 1));
    return v;
  endfunction

  // ready_i driver: fixed high, scripted stall window, or 50% random
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        ready_i = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        ready_i = 1'($urandom_range(0, 1));
      end else begin
        ready_i = 1'b1;
      end
    end
  end

  // Monitor: samples mid-cycle, scoreboards acceptances and deliveries
  bit           stall_prev = 1'b0;
  logic [N-1:0] held;
  always @(negedge clk) begin
    if (!rst) begin
      chk("ready_o_in_reset", 64'(ready_o), 64'd0);
      sb.delete();
      stall_prev = 1'b0;
    end else begin
      chk("ready_o_rule", 64'(ready_o), 64'(!(valid_o && !ready_i)));
      if (stall_prev) begin
        chk("stall_hold_valid", 64'(valid_o), 64'd1);
        chk("stall_hold_result", 64'(result_o), 64'(held));
      end
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          chk("spurious_valid_o", 64'(valid_o), 64'd0);
        end else begin
          chk("result", 64'(result_o), 64'(sb.pop_front()));
          n_del++;
        end
      end
      if (valid_i && ready_o) sb.push_back(model(mode_i, a_i, b_i, c_i));
      if (valid_o && !ready_i) n_stall++;
      stall_prev = valid_o && !ready_i;
      held       = result_o;
    end
  end

  task automatic send(input logic m, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [N-1:0] c);
    int unsigned guard;
    logic acc;
    guard   = 0;
    mode_i  = m;
    a_i     = a;
    b_i     = b;
    c_i     = c;
    valid_i = 1'b1;
    do begin
      @(negedge clk);
      acc = ready_o;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    valid_i = 1'b0;
  endtask

  task automatic send_rand();
    send(1'($urandom_range(0, 1)), rand_vec(), rand_vec(), rand_vec());
  endtask

  task automatic directed(input string tag, input logic m, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic [N-1:0] c,
                          input logic [N-1:0] exp);
    mode_i  = m;
    a_i     = a;
    b_i     = b;
    c_i     = c;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    chk({tag, "_lat1"}, 64'(valid_o), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_lat2"}, 64'(valid_o), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, "_lat3"}, 64'(valid_o), 64'd1);
    chk({tag, "_value"}, 64'(result_o), 64'(exp));
  endtask

  task automatic drain(input string tag);
    int unsigned guard;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

  initial begin
    int unsigned d0;
    rst     = 1'b0;
    valid_i = 1'b0;
    mode_i  = 1'b0;
    a_i     = '0;
    b_i     = '0;
    c_i     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid_o", 64'(valid_o), 64'd0);
    chk("reset_result_o", 64'(result_o), 64'd0);
    chk("reset_ready_o", 64'(ready_o), 64'd0);
    rst = 1'b1;

    directed("mul", 1'b0, pack4(0, 1, 3328, 1234), pack4(0, 3328, 3328, 2),
             pack4(17, 99, 3000, 5), pack4(0, 3328, 1, 2468));
    directed("fma", 1'b1, pack4(3328, 2, 0, 5), pack4(3328, 3, 0, 7),
             pack4(3328, 3325, 3328, 9), pack4(0, 2, 3328, 44));
    drain("directed");

    // Backpressure: 4-cycle stall window opened mid-stream
    d0      = n_del;
    n_stall = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) stall_left = 4;
      send_rand();
    end
    drain("backpressure");
    chk("bp_stall_cycles", 64'(n_stall), 64'd4);
    chk("bp_delivered", 64'(n_del - d0), 64'd10);

    // Throughput: back-to-back beats must deliver one per cycle after 3 cycles
    d0 = n_del;
    for (int i = 0; i < 500; i++) send_rand();
    repeat (3) @(posedge clk);
    #1;
    chk("throughput_count", 64'(n_del - d0), 64'd500);
    drain("throughput");

    // Reset with three beats in flight
    d0 = n_del;
    for (int i = 0; i < 3; i++) send_rand();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk("midreset_valid_o", 64'(valid_o), 64'd0);
    chk("midreset_result_o", 64'(result_o), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("midreset_no_output", 64'(n_del - d0), 64'd0);

    // Random ready and random valid gaps
    rand_ready = 1'b1;
    d0 = n_del;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_rand();
    end
    rand_ready = 1'b0;
    drain("random");
    chk("random_delivered", 64'(n_del - d0), 64'd300);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
